// File: rtl/mem_stream_pkg.sv
// Shared types and constants for the memory stream reader.
package mem_stream_pkg;

  // Controller states: waiting for a command, issuing reads, waiting for
  // the buffered/in-flight words to leave.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Output buffer depth; two entries are enough to sustain one word per
  // cycle across the one-cycle memory read latency.
  localparam int unsigned FifoDepth    = 2;
  localparam int unsigned FifoCntWidth = $clog2(FifoDepth + 1);
  localparam int unsigned FifoPtrWidth = $clog2(FifoDepth);

endpackage

// File: rtl/mem_stream_fifo2.sv
// Two-entry FIFO buffering memory read data ahead of the output stream.
// Head word is presented combinationally from storage (first-word fall-through).
module mem_stream_fifo2
  import mem_stream_pkg::*;
#(
  parameter int DataWidth = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic [DataWidth-1:0]    push_data,
  input  logic                    pop,
  output logic [FifoCntWidth-1:0] count,
  output logic [DataWidth-1:0]    data,
  output logic                    valid
);

  logic [DataWidth-1:0]    mem_q [FifoDepth];
  logic [FifoPtrWidth-1:0] wr_ptr_q;
  logic [FifoPtrWidth-1:0] rd_ptr_q;
  logic [FifoCntWidth-1:0] count_q;
  logic                    full;
  logic                    do_push;
  logic                    do_pop;

  assign full    = (count_q == FifoCntWidth'(FifoDepth));
  assign do_pop  = pop && valid;
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  // Storage, pointers and occupancy update.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the storage is cleared as well so the head reads 0 after reset,
      // not just flagged empty; with two entries this costs almost nothing.
      for (int i = 0; i < FifoDepth; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so a simultaneous push and
      // pop both see the pre-edge pointers and count.
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign count = count_q;
  assign valid = (count_q != '0);
  assign data  = mem_q[rd_ptr_q];

endmodule

// File: rtl/mem_stream_reader.sv
// Memory stream reader: accepts (address, length) commands, reads that many
// consecutive words from a one-cycle-latency memory port and streams them out
// with a last-word flag and done/err status pulses.
// Optional build macro MEM_STREAM_READER_WRAP_EN: when defined, commands that
// run past the top of memory are accepted and the address wraps; when
// undefined they are rejected with an err pulse and no reads.
module mem_stream_reader
  import mem_stream_pkg::*;
#(
  parameter int AddrWidth = 8,
  parameter int DataWidth = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [AddrWidth-1:0] cmd_addr,
  input  logic [AddrWidth:0]   cmd_len,
  output logic                 rden,
  output logic [AddrWidth-1:0] raddr,
  input  logic [DataWidth-1:0] rdata,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DataWidth-1:0] out_data,
  output logic                 out_last,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  state_e                  state_q;
  state_e                  state_d;
  logic [AddrWidth-1:0]    addr_q;       // next address to issue
  logic [AddrWidth:0]      remaining_q;  // reads still to issue
  logic [AddrWidth:0]      out_rem_q;    // words still to hand out
  logic                    rd_pend_q;    // read issued last cycle, data on rdata now
  logic                    done_zero_q;  // zero-length command completion
  logic                    err_q;

  logic                    cmd_fire;
  logic                    len_zero;
  logic                    range_bad;
  logic                    start;
  logic                    pop;
  logic [FifoCntWidth-1:0] fifo_count;
  logic                    fifo_valid;
  logic [DataWidth-1:0]    fifo_data;
  logic [FifoCntWidth:0]   occ_after;

  assign cmd_fire = cmd_valid && cmd_ready;
  assign len_zero = (cmd_len == '0);

`ifdef MEM_STREAM_READER_WRAP_EN
  assign range_bad = 1'b0;
`else
  localparam logic [AddrWidth+1:0] MemDepth = {2'b01, {AddrWidth{1'b0}}};
  logic [AddrWidth+1:0] end_addr;
  assign end_addr  = {2'b00, cmd_addr} + {1'b0, cmd_len};
  assign range_bad = (end_addr > MemDepth);
`endif

  assign start = cmd_fire && !len_zero && !range_bad;
  assign pop   = fifo_valid && out_ready;

  // Words buffered or in flight once this cycle's pop has left; a new read
  // is only issued while that leaves room in the FIFO for its data.
  assign occ_after = (FifoCntWidth + 1)'(fifo_count)
                   + (FifoCntWidth + 1)'(rd_pend_q)
                   - (FifoCntWidth + 1)'(pop);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assignment first so no path through the case leaves
    // state_d unassigned, which would otherwise infer a latch.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = READ;
      READ:    if (rden && (remaining_q == (AddrWidth + 1)'(1))) state_d = DRAIN;
      DRAIN:   if (pop && out_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State-decoded outputs and read issue.
  always_comb begin
    cmd_ready = 1'b0;
    busy      = 1'b0;
    rden      = 1'b0;
    unique case (state_q)
      IDLE:  cmd_ready = 1'b1;
      READ: begin
        busy = 1'b1;
        rden = (remaining_q != '0)
            && (occ_after < (FifoCntWidth + 1)'(FifoDepth));
      end
      DRAIN: busy = 1'b1;
      default: ;
    endcase
  end

  // Command counters, read-pending tracker and status pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q      <= '0;
      remaining_q <= '0;
      out_rem_q   <= '0;
      rd_pend_q   <= 1'b0;
      done_zero_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      rd_pend_q   <= rden;
      done_zero_q <= cmd_fire && len_zero;
      err_q       <= cmd_fire && !len_zero && range_bad;
      if (start) begin
        addr_q      <= cmd_addr;
        remaining_q <= cmd_len;
        out_rem_q   <= cmd_len;
      end else begin
        if (rden) begin
          addr_q      <= addr_q + 1'b1;  // wraps modulo memory depth
          remaining_q <= remaining_q - 1'b1;
        end
        if (pop) begin
          out_rem_q <= out_rem_q - 1'b1;
        end
      end
    end
  end

  mem_stream_fifo2 #(
    .DataWidth(DataWidth)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (rd_pend_q),
    .push_data(rdata),
    .pop      (pop),
    .count    (fifo_count),
    .data     (fifo_data),
    .valid    (fifo_valid)
  );

  assign raddr     = addr_q;
  assign out_valid = fifo_valid;
  assign out_data  = fifo_data;
  assign out_last  = fifo_valid && (out_rem_q == (AddrWidth + 1)'(1));
  assign done      = done_zero_q || (pop && out_last);
  assign err       = err_q;

endmodule

// File: doc/mem_stream_reader.md
MEM_STREAM_READER -- requirements
Module: mem_stream_reader

Interface
REQ-001 Parameter AddrWidth, default 8, SHALL set the memory address width; memory depth is 2**AddrWidth words.
REQ-002 Parameter DataWidth, default 64, SHALL set the memory word and stream data width.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset: synchronous, active-low.
REQ-005 cmd_valid  input  1 / cmd_ready  output  1  SHALL form the command handshake, with a transfer when both are high.
REQ-006 cmd_addr  input  AddrWidth  SHALL give the first word address.
REQ-007 cmd_len  input  AddrWidth+1  SHALL give the word count, 0..2**AddrWidth.
REQ-008 rden  output  1 / raddr  output  AddrWidth  SHALL drive the memory read port.
REQ-009 rdata  input  DataWidth  SHALL be the memory read data, valid the cycle after rden.
REQ-010 out_valid  output  1 / out_ready  input  1  SHALL form the output stream handshake.
REQ-011 out_data  output  DataWidth / out_last  output  1  SHALL carry the word and the final-word flag.
REQ-012 busy  output  1, done  output  1 (one-cycle pulse), err  output  1 (one-cycle pulse) SHALL report status.

Function
REQ-013 States SHALL be IDLE, READ and DRAIN.
REQ-014 cmd_ready SHALL be high only in IDLE; busy SHALL be high in READ and DRAIN.
REQ-015 On a command handshake with cmd_len>0: go to READ, load address counter = cmd_addr and remaining = cmd_len.
REQ-016 On a command handshake with cmd_len=0: stay IDLE, pulse done next cycle, issue no reads.
REQ-017 In READ, rden SHALL assert when (fifo_count + inflight - pop) < 2, where pop = out_valid & out_ready; each issue increments raddr and decrements remaining.
REQ-018 The first rden SHALL occur the cycle after the command handshake.
REQ-019 rdata SHALL be written into a 2-entry FIFO the cycle after each rden; the head is presented as out_data/out_valid the following cycle, giving 3 cycles from command handshake to first out_valid.
REQ-020 Sustained throughput SHALL be 1 word/cycle while out_ready stays high.
REQ-021 Data SHALL never be dropped or duplicated under any out_ready pattern; out_data SHALL hold stable while out_valid & !out_ready.
REQ-022 READ→DRAIN SHALL occur when remaining reaches 0 after the last issue.
REQ-023 DRAIN→IDLE SHALL occur on the handshake of the word with out_last=1; done SHALL pulse in the same cycle as that handshake.
REQ-024 out_last SHALL be high only on the cmd_len-th word of a command.
REQ-025 raddr SHALL wrap modulo 2**AddrWidth.

Reset
REQ-026 While rst_n=0 at a clock edge, state SHALL go to IDLE, FIFO and inflight SHALL clear, and the outputs SHALL be: rden=0, raddr=0, out_valid=0, out_last=0, out_data=0, busy=0, done=0, err=0.
REQ-027 A reset during READ or DRAIN SHALL abandon the command; no stale word SHALL appear after reset is released.

Configuration
REQ-028 Macro MEM_STREAM_READER_WRAP_EN defined: commands with cmd_addr+cmd_len > 2**AddrWidth SHALL be accepted and wrap per REQ-025; err SHALL stay 0.
REQ-029 Macro MEM_STREAM_READER_WRAP_EN undefined: such a command SHALL be consumed in IDLE with no reads and no done, and err SHALL pulse the next cycle.

Structure
REQ-030 Package mem_stream_pkg SHALL hold the state enum typedef (IDLE/READ/DRAIN) and the FIFO depth constant (2).
REQ-031 Sub-module mem_stream_fifo2 SHALL implement the 2-entry FIFO, with push/pop/count, data and valid outputs, and synchronous active-low reset.

Verification
REQ-032 addr=0x10, len=4, out_ready=1 → raddr 0x10..0x13 on consecutive cycles; 4 words in order; out_last on the 4th; done with the 4th handshake; first out_valid 3 cycles after the command.
REQ-033 len=8, out_ready toggling 1/0 each cycle → all 8 words delivered exactly once and in order; never more than 2 reads outstanding plus buffered.
REQ-034 len=0 → no rden; done pulses 1 cycle after the command; cmd_ready back high.
REQ-035 addr=0xFE, len=4, AddrWidth=8: WRAP_EN → raddr 0xFE, 0xFF, 0x00, 0x01; without WRAP_EN → err pulse, no rden, no done.
REQ-036 rst_n=0 pulsed after 2 words of a len=6 command → all outputs reach reset values; a new len=2 command then returns only its own 2 words.
REQ-037 len=256, addr=0 → 256 words, out_last only on word 256, single done pulse.
